// File: rtl/decode_operand_stage.sv
// rtl/decode_operand_stage.sv - ID stage: decode, operand select, load-use stall, ID/EX register
// Optional macro WB_BYPASS_EN adds a write-through bypass from write-back onto the operands.
module decode_operand_stage #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_d,
  input  logic [WIDTH-1:0]        instr_d,
  input  logic [WIDTH-1:0]        pc_d,
  input  logic                    flush_e,
  output logic [ADDRESSWIDTH-1:0] ra1,
  output logic [ADDRESSWIDTH-1:0] ra2,
  input  logic [WIDTH-1:0]        rd1,
  input  logic [WIDTH-1:0]        rd2,
  input  logic                    we_w,
  input  logic [ADDRESSWIDTH-1:0] wa_w,
  input  logic [WIDTH-1:0]        wd_w,
  output logic                    stall_f,
  output logic                    valid_e,
  output logic [3:0]              op_e,
  output logic [ADDRESSWIDTH-1:0] rd_e,
  output logic [WIDTH-1:0]        srca_e,
  output logic [WIDTH-1:0]        srcb_e,
  output logic [WIDTH-1:0]        imm_e,
  output logic                    regwrite_e,
  output logic                    memread_e,
  output logic                    memwrite_e,
  output logic                    branch_e
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LDR  = 4'b0101;
  localparam logic [3:0] OP_STR  = 4'b0110;
  localparam logic [3:0] OP_B    = 4'b0111;

  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = '1;

  logic [3:0]              op;
  logic [ADDRESSWIDTH-1:0] rd_f;
  logic [ADDRESSWIDTH-1:0] rs1_f;
  logic [ADDRESSWIDTH-1:0] rs2_f;
  logic                    dec_regwrite;
  logic                    dec_memread;
  logic                    dec_memwrite;
  logic                    dec_branch;
  logic                    uses_ra1;
  logic                    uses_ra2;
  logic                    hz;
  logic [WIDTH-1:0]        srca;
  logic [WIDTH-1:0]        srcb;
  logic [WIDTH-1:0]        imm;

  assign op    = instr_d[15:12];
  assign rd_f  = instr_d[8 +: ADDRESSWIDTH];
  assign rs1_f = instr_d[4 +: ADDRESSWIDTH];
  assign rs2_f = instr_d[0 +: ADDRESSWIDTH];
  assign imm   = {{(WIDTH-4){1'b0}}, instr_d[3:0]};

  // STR reads its store data through port 2, addressed by the rd field
  assign ra1 = rs1_f;
  assign ra2 = (op == OP_STR) ? rd_f : rs2_f;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    uses_ra1     = 1'b0;
    uses_ra2     = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_regwrite = 1'b1;
        uses_ra1     = 1'b1;
        uses_ra2     = 1'b1;
      end
      OP_ADDI: begin
        dec_regwrite = 1'b1;
        uses_ra1     = 1'b1;
      end
      OP_LDR: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        uses_ra1     = 1'b1;
      end
      OP_STR: begin
        dec_memwrite = 1'b1;
        uses_ra1     = 1'b1;
        uses_ra2     = 1'b1;
      end
      OP_B: begin
        dec_branch = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // PC reads (address 1111) never depend on a load result
  assign hz = valid_d & valid_e & memread_e & (rd_e != PC_ADDR) &
              (((rd_e == ra1) & uses_ra1) | ((rd_e == ra2) & uses_ra2));

  assign stall_f = hz & ~flush_e;

`ifdef WB_BYPASS_EN
  // Register file returns the old value when written and read in the same cycle
  assign srca = (we_w && (wa_w == ra1) && (ra1 != PC_ADDR)) ? wd_w : rd1;
  assign srcb = (we_w && (wa_w == ra2) && (ra2 != PC_ADDR)) ? wd_w : rd2;
`else
  logic unused_wb;
  assign unused_wb = ^{we_w, wa_w, wd_w, pc_d};
  assign srca = rd1;
  assign srcb = rd2;
`endif

`ifdef WB_BYPASS_EN
  logic unused_pc;
  assign unused_pc = ^pc_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memread_e  <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
    end else if (flush_e || hz) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memread_e  <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
    end else begin
      valid_e    <= valid_d;
      regwrite_e <= dec_regwrite & valid_d;
      memread_e  <= dec_memread  & valid_d;
      memwrite_e <= dec_memwrite & valid_d;
      branch_e   <= dec_branch   & valid_d;
    end
  end

  // Data fields hold only while stalling; a flush still lets them load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_e   <= '0;
      rd_e   <= '0;
      srca_e <= '0;
      srcb_e <= '0;
      imm_e  <= '0;
    end else if (!stall_f) begin
      op_e   <= op;
      rd_e   <= rd_f;
      srca_e <= srca;
      srcb_e <= srcb;
      imm_e  <= imm;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// tb/tb_decode_operand_stage.sv - directed self-checking bench for decode_operand_stage
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d;
  logic [15:0] instr_d;
  logic [15:0] pc_d;
  logic        flush_e;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        we_w;
  logic [3:0]  wa_w;
  logic [15:0] wd_w;
  logic        stall_f;
  logic        valid_e;
  logic [3:0]  op_e;
  logic [3:0]  rd_e;
  logic [15:0] srca_e;
  logic [15:0] srcb_e;
  logic [15:0] imm_e;
  logic        regwrite_e;
  logic        memread_e;
  logic        memwrite_e;
  logic        branch_e;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_operand_stage #(.WIDTH(16), .ADDRESSWIDTH(4)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .flush_e(flush_e), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we_w(we_w), .wa_w(wa_w), .wd_w(wd_w), .stall_f(stall_f), .valid_e(valid_e),
    .op_e(op_e), .rd_e(rd_e), .srca_e(srca_e), .srcb_e(srcb_e), .imm_e(imm_e),
    .regwrite_e(regwrite_e), .memread_e(memread_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ctrl();
    return {12'h000, regwrite_e, memread_e, memwrite_e, branch_e};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".valid_e"}, {15'h0, valid_e}, 16'h0);
    check({tag, ".ctrl"}, ctrl(), 16'h0);
    check({tag, ".op_rd"}, {8'h00, op_e, rd_e}, 16'h0);
    check({tag, ".srca_e"}, srca_e, 16'h0);
    check({tag, ".srcb_e"}, srcb_e, 16'h0);
    check({tag, ".imm_e"}, imm_e, 16'h0);
    check({tag, ".stall_f"}, {15'h0, stall_f}, 16'h0);
  endtask

  initial begin
    reset   = 1'b1;
    valid_d = 1'b0;
    instr_d = 16'h0000;
    pc_d    = 16'h0000;
    flush_e = 1'b0;
    rd1     = 16'h0000;
    rd2     = 16'h0000;
    we_w    = 1'b0;
    wa_w    = 4'h0;
    wd_w    = 16'h0000;
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // ADD r3,r1,r2
    valid_d = 1'b1; instr_d = 16'h0312; rd1 = 16'h0005; rd2 = 16'h0007;
    #1;
    check("add.ra1", {12'h0, ra1}, 16'h0001);
    check("add.ra2", {12'h0, ra2}, 16'h0002);
    tick();
    check("add.valid_e", {15'h0, valid_e}, 16'h0001);
    check("add.op_rd", {8'h00, op_e, rd_e}, 16'h0003);
    check("add.srca_e", srca_e, 16'h0005);
    check("add.srcb_e", srcb_e, 16'h0007);
    check("add.ctrl", ctrl(), 16'h0008);

    // LDR r4,[r1] then ADD r5,r4,r2: one-cycle stall
    instr_d = 16'h5410; rd1 = 16'h0100; rd2 = 16'h0000;
    #1;
    check("ldr.stall_f", {15'h0, stall_f}, 16'h0);
    tick();
    check("ldr.ctrl", ctrl(), 16'h000C);
    check("ldr.rd_e", {12'h0, rd_e}, 16'h0004);
    instr_d = 16'h0542; rd1 = 16'h0033; rd2 = 16'h0002;
    #1;
    check("hz.stall_f", {15'h0, stall_f}, 16'h0001);
    tick();
    check("hz.bubble_valid", {15'h0, valid_e}, 16'h0);
    check("hz.bubble_ctrl", ctrl(), 16'h0);
    check("hz.held_srca", srca_e, 16'h0100);
    check("hz.stall_cleared", {15'h0, stall_f}, 16'h0);
    tick();
    check("hz.add_valid", {15'h0, valid_e}, 16'h0001);
    check("hz.add_op_rd", {8'h00, op_e, rd_e}, 16'h0005);
    check("hz.add_srca", srca_e, 16'h0033);

    // Same pair with a flush during the hazard cycle
    instr_d = 16'h5410; rd1 = 16'h0100;
    tick();
    instr_d = 16'h0542; rd1 = 16'h0033; flush_e = 1'b1;
    #1;
    check("fl.stall_f", {15'h0, stall_f}, 16'h0);
    tick();
    check("fl.bubble_valid", {15'h0, valid_e}, 16'h0);
    check("fl.bubble_ctrl", ctrl(), 16'h0);
    flush_e = 1'b0;
    #1;
    check("fl.no_restall", {15'h0, stall_f}, 16'h0);

    // LDR r15 then ADDI r2,r15,#9: PC reads never hazard
    instr_d = 16'h5F00; rd1 = 16'h0000;
    tick();
    check("ldr15.rd_e", {12'h0, rd_e}, 16'h000F);
    check("ldr15.memread", {15'h0, memread_e}, 16'h0001);
    instr_d = 16'h42F9; pc_d = 16'h0040; rd1 = 16'h0040; rd2 = 16'h0000;
    #1;
    check("addi.stall_f", {15'h0, stall_f}, 16'h0);
    tick();
    check("addi.srca_e", srca_e, 16'h0040);
    check("addi.imm_e", imm_e, 16'h0009);
    check("addi.op_rd", {8'h00, op_e, rd_e}, 16'h0042);
    check("addi.ctrl", ctrl(), 16'h0008);

    // STR r6,[r1]: port 2 reads rd
    instr_d = 16'h6610; rd1 = 16'h0200; rd2 = 16'hCAFE;
    #1;
    check("str.ra2", {12'h0, ra2}, 16'h0006);
    tick();
    check("str.ctrl", ctrl(), 16'h0002);
    check("str.srcb_e", srcb_e, 16'hCAFE);

    // B and NOP
    instr_d = 16'h7000;
    tick();
    check("b.ctrl", ctrl(), 16'h0001);
    instr_d = 16'hF123;
    tick();
    check("nop.valid_e", {15'h0, valid_e}, 16'h0001);
    check("nop.ctrl", ctrl(), 16'h0);

    // Invalid slot
    valid_d = 1'b0; instr_d = 16'h0312;
    tick();
    check("inv.valid_e", {15'h0, valid_e}, 16'h0);
    check("inv.ctrl", ctrl(), 16'h0);

    // Same-cycle write-back to r1
    valid_d = 1'b1; instr_d = 16'h0312; rd1 = 16'h1111; rd2 = 16'h2222;
    we_w = 1'b1; wa_w = 4'h1; wd_w = 16'hBEEF;
    tick();
`ifdef WB_BYPASS_EN
    check("wb.srca_e", srca_e, 16'hBEEF);
`else
    check("wb.srca_e", srca_e, 16'h1111);
`endif
    check("wb.srcb_e", srcb_e, 16'h2222);
    we_w = 1'b0;

    // Asynchronous reset while valid_e=1, no clock edge in between
    check("pre_rst.valid_e", {15'h0, valid_e}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b0;

    // First edge after deassertion captures normally
    instr_d = 16'h0312; rd1 = 16'h0005; rd2 = 16'h0007;
    tick();
    check("post_rst.valid_e", {15'h0, valid_e}, 16'h0001);
    check("post_rst.srcb_e", srcb_e, 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Instruction-decode / operand-fetch stage of the 16-bit pipeline.
- Takes the fetched instruction and its PC from the IF/ID boundary and drives the register-file read addresses.
- Captures the returned operands, the decoded control and the destination into the ID/EX pipeline register.
- Detects load-use hazards, stalls fetch and injects a bubble; honours branch flushes from EX.

Parameters:
- WIDTH, 16, datapath and instruction width.
- ADDRESSWIDTH, 4, register address width; address 4'b1111 reads as PC.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- valid_d  input  1  instr_d/pc_d hold a real instruction.
- instr_d  input  WIDTH  instruction: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
- pc_d  input  WIDTH  PC of instr_d.
- flush_e  input  1  branch taken in EX; kill the instruction in ID.
- ra1  output  ADDRESSWIDTH  register-file read address 1 (= rs1).
- ra2  output  ADDRESSWIDTH  register-file read address 2 (= rs2, or rd for STR).
- rd1, rd2  input  WIDTH  register-file read data (combinational).
- we_w  input  1  write-back write enable (same signal as the register-file we3).
- wa_w  input  ADDRESSWIDTH  write-back address.
- wd_w  input  WIDTH  write-back data.
- stall_f  output  1  hold PC and the IF/ID register this cycle.
- valid_e  output  1  ID/EX holds a live instruction.
- op_e  output  4  registered opcode.
- rd_e  output  ADDRESSWIDTH  registered destination.
- srca_e, srcb_e  output  WIDTH  registered operands.
- imm_e  output  WIDTH  zero-extended imm4.
- regwrite_e, memread_e, memwrite_e, branch_e  output  1  registered control.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR: regwrite.
  - 0100 ADDI: regwrite, uses imm.
  - 0101 LDR: regwrite + memread.
  - 0110 STR: memwrite; ra2 = rd, data = srcb.
  - 0111 B: branch.
  - Any other opcode: NOP, all control 0.
- ra1/ra2 are combinational from instr_d. Outputs are valid even when valid_d=0; their value is then don't-care.
- Load-use hazard:
  - Condition: `hz = valid_d & valid_e & memread_e & (rd_e != 4'b1111) & ((rd_e == ra1 & uses_ra1) | (rd_e == ra2 & uses_ra2))`.
  - uses_ra1 = all ops except B and NOP.
  - uses_ra2 = ADD, SUB, AND, OR, STR.
- stall_f = hz & ~flush_e (combinational).
- ID/EX update on each rising clk, in priority order:
  1. flush_e: bubble (valid_e=0, all control 0). A flush overrides a stall.
  2. hz: bubble. IF/ID is held by stall_f, so the same instruction re-decodes next cycle. The stall lasts exactly 1 cycle because the bubble clears memread_e.
  3. otherwise: capture. valid_e = valid_d. Control = decoded control & valid_d.
- Data fields (srca_e, srcb_e, imm_e, rd_e, op_e) load on every non-stall cycle.
  - Their value is don't-care when valid_e=0, but they must never be X after reset.
- Operand source: address 1111 returns PC. pc_d comes through the register file, so it is used as delivered on rd1/rd2. PC is never bypassed.
- Reset (asynchronous, active-high):
  - valid_e, control outputs, op_e, rd_e, srca_e, srcb_e and imm_e all 0.
  - stall_f follows combinationally; it is 0 because valid_e=0.
- Reset deasserting mid-stream: the first edge after deassertion captures normally.
- Latency: 1 cycle from the IF/ID boundary to ID/EX.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-through bypass.
  - If we_w & (wa_w == ra1) & (ra1 != 4'b1111), srca uses wd_w instead of rd1.
  - Same rule for ra2 and srcb.
  - Covers the same-cycle write/read case where the register file returns the old value.
- Undefined: srca/srcb come directly from rd1/rd2. Software must separate a producer from its WB-cycle consumer.

Test Plan:
- Reset mid-run: assert reset asynchronously while valid_e=1 -> all ID/EX outputs 0 immediately, no clock needed; stall_f=0.
- ADD r3,r1,r2 with rd1=0x0005, rd2=0x0007 -> next edge: valid_e=1, op_e=0, rd_e=3, srca_e=0x0005, srcb_e=0x0007, regwrite_e=1.
- LDR r4,[r1] followed by ADD r5,r4,r2 -> stall_f=1 for exactly 1 cycle. One bubble (valid_e=0) appears. ADD enters ID/EX on the following edge.
- Same LDR/ADD pair with flush_e=1 during the hazard cycle -> stall_f=0, bubble captured, no repeated stall.
- ADDI r2,r15,#9 with pc_d=0x0040 -> srca_e=0x0040, imm_e=0x0009; no hazard even if rd_e=15 with memread_e=1.
- WB_BYPASS_EN: we_w=1, wa_w=1, wd_w=0xBEEF, rd1=0x1111, ADD reads r1 -> srca_e=0xBEEF. Without the macro -> srca_e=0x1111.
